// File: rtl/dmem_bytelane_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared access-size encodings and byte-lane helper functions for
//             the byte-lane data memory (dmem_bytelane).
//  Contents : SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL  - req_size encodings
//             lane_mask(size, lane)           - 4-bit write strobe
//             misaligned(size, lane)          - alignment fault for half/word
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Byte strobe for a store; illegal sizes strobe nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Halves need an even address, words a 4-byte aligned one.
    // The illegal size is reported separately by the caller.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = |lane;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bytelane_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bytelane_if
//  Purpose  : Request/response bundle between the MEM stage and the data memory.
//  Signals  : req_valid, req_write, req_size[1:0], req_unsigned,
//             addr[ADDR_W-1:0], wdata[31:0]          (master -> slave)
//             rsp_valid, rsp_err, rdata[31:0],
//             err_count[ERRCNT_W-1:0]                (slave -> master)
//  Modports : master (pipeline side), slave (memory side)
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_bytelane_if #(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
);
    logic                req_valid;
    logic                req_write;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [ADDR_W-1:0]   addr;
    logic [31:0]         wdata;
    logic                rsp_valid;
    logic                rsp_err;
    logic [31:0]         rdata;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, addr, wdata,
        input  rsp_valid, rsp_err, rdata, err_count
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, addr, wdata,
        output rsp_valid, rsp_err, rdata, err_count
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bytelane_load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_load_extend
//  Purpose  : Combinational load formatter: picks the byte/half addressed by
//             the lane out of a raw memory word and sign- or zero-extends it.
//  Ports    : i_rawWord[31:0]  raw little-endian memory word
//             i_lane[1:0]      byte offset of the access
//             i_size[1:0]      access size (SZ_* encoding)
//             i_unsigned       1 = zero-extend, 0 = sign-extend (ignored for word)
//             o_rdata[31:0]    formatted load data (0 for illegal size)
//  Revision : 1.0  initial release
// ============================================================================
module dmem_load_extend
    import dmem_pkg::*;
(
    input  wire logic [31:0] i_rawWord,
    input  wire logic [1:0]  i_lane,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    output logic      [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = 8'h00;
        w_half  = 16'h0000;
        o_rdata = 32'h0000_0000;

        case (i_lane)
            2'd0:    w_byte = i_rawWord[7:0];
            2'd1:    w_byte = i_rawWord[15:8];
            2'd2:    w_byte = i_rawWord[23:16];
            default: w_byte = i_rawWord[31:24];
        endcase

        // Halves are always aligned here, so only lane[1] selects.
        w_half = i_lane[1] ? i_rawWord[31:16] : i_rawWord[15:0];

        case (i_size)
            SZ_BYTE: o_rdata = i_unsigned ? {24'h000000, w_byte}
                                          : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = i_unsigned ? {16'h0000, w_half}
                                          : {{16{w_half[15]}}, w_half};
            SZ_WORD: o_rdata = i_rawWord;
            default: o_rdata = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bytelane.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bytelane
//  Purpose  : MEM-stage data memory with byte/half/word loads and stores,
//             byte-lane strobes, sign/zero load extension, one-cycle
//             registered response and a saturating error counter.
//  Ports    : clk     clock, all state on the rising edge
//             rst_n   asynchronous active-low reset (memory array not reset)
//             bus     dmem_bytelane_if.slave request/response bundle
//  Params   : ADDR_W   byte-address width
//             DEPTH    words of storage (power of two, >= 4)
//             OOR_WRAP 0: index >= DEPTH is an error; 1: index wraps modulo DEPTH
//             ERRCNT_W width of the saturating error counter
//  Revision : 1.0  initial release
// ============================================================================
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int OOR_WRAP = 0,
    parameter int ERRCNT_W = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    dmem_bytelane_if.slave bus
);

    localparam int c_IDX_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_memIdx;
    logic [1:0]         w_lane;
    logic               w_idxHigh;
    logic               w_oor;
    logic               w_err;
    logic               w_doWrite;
    logic               w_doRead;
    logic [3:0]         w_mask;
    logic [31:0]        w_wdataRep;

    assign w_memIdx = bus.addr[c_IDX_W+1:2];
    assign w_lane   = bus.addr[1:0];

    // Any set word-index bit above the array's own index bits means the
    // access lies beyond DEPTH.
    generate
        if (ADDR_W - 2 > c_IDX_W) begin : g_idxHigh
            assign w_idxHigh = |bus.addr[ADDR_W-1:c_IDX_W+2];
        end else begin : g_noIdxHigh
            assign w_idxHigh = 1'b0;
        end
    endgenerate

    assign w_oor     = (OOR_WRAP == 0) && w_idxHigh;
    assign w_err     = (bus.req_size == SZ_ILL) || misaligned(bus.req_size, w_lane) || w_oor;
    assign w_doWrite = bus.req_valid &&  bus.req_write && !w_err;
    assign w_doRead  = bus.req_valid && !bus.req_write && !w_err;
    assign w_mask    = lane_mask(bus.req_size, w_lane);

    // Replicate the right-justified store data across all lanes; the strobe
    // then decides which copy lands where.
    always_comb begin
        w_wdataRep = bus.wdata;
        case (bus.req_size)
            SZ_BYTE: w_wdataRep = {4{bus.wdata[7:0]}};
            SZ_HALF: w_wdataRep = {2{bus.wdata[15:0]}};
            default: w_wdataRep = bus.wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane, synchronous read and write.
    // A store and a load never share an edge, so a load right after a
    // store to the same word sees the new data.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rawByte;

            always_ff @(posedge clk) begin
                if (w_doWrite && w_mask[gi]) begin
                    r_mem[w_memIdx] <= w_wdataRep[8*gi +: 8];
                end
                if (w_doRead) begin
                    r_rawByte <= r_mem[w_memIdx];
                end
            end
        end
    endgenerate

    logic [31:0] w_rawWord;
    assign w_rawWord = {g_lane[3].r_rawByte, g_lane[2].r_rawByte,
                        g_lane[1].r_rawByte, g_lane[0].r_rawByte};

    // ------------------------------------------------------------------
    // Response registers and error counter
    // ------------------------------------------------------------------
    logic                r_rspValid;
    logic                r_rspErr;
    logic                r_loadOk;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ERRCNT_W-1:0] r_errCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_loadOk   <= 1'b0;
            r_lane     <= 2'b00;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_errCount <= '0;
        end else begin
            r_rspValid <= bus.req_valid;
            r_rspErr   <= bus.req_valid && w_err;
            r_loadOk   <= w_doRead;
            if (bus.req_valid) begin
                r_lane     <= w_lane;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
            end
            if (bus.req_valid && w_err && (r_errCount != '1)) begin
                r_errCount <= r_errCount + ERRCNT_W'(1);
            end
        end
    end

    logic [31:0] w_extData;

    dmem_load_extend u_loadExtend (
        .i_rawWord  (w_rawWord),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_rdata    (w_extData)
    );

    // The raw byte registers are not reset, so the data path is gated by the
    // reset-cleared load flag: stores, errors and idle cycles read as zero.
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_err   = r_rspErr;
    assign bus.rdata     = r_loadOk ? w_extData : 32'h0000_0000;
    assign bus.err_count = r_errCount;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_bytelane
//  Purpose  : Self-checking bench for dmem_bytelane. Two instances: A with
//             out-of-range errors (OOR_WRAP=0), B with index wrap and a 2-bit
//             error counter so saturation is reachable in a few requests.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_bytelane;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_bytelane_if #(.ADDR_W(32), .ERRCNT_W(8)) busA ();
    dmem_bytelane_if #(.ADDR_W(32), .ERRCNT_W(2)) busB ();

    dmem_bytelane #(.ADDR_W(32), .DEPTH(1024), .OOR_WRAP(0), .ERRCNT_W(8)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    dmem_bytelane #(.ADDR_W(32), .DEPTH(1024), .OOR_WRAP(1), .ERRCNT_W(2)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    exp_t qA[$];
    exp_t qB[$];
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_size = SZ_BYTE;
        busA.req_unsigned = 1'b0; busA.addr = 32'h0; busA.wdata = 32'h0;
        busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_size = SZ_BYTE;
        busB.req_unsigned = 1'b0; busB.addr = 32'h0; busB.wdata = 32'h0;
    endtask

    // Pop the expected response for each instance, or require silence.
    task automatic checkRsp(input string tag);
        exp_t e;
        if (qA.size() > 0) begin
            e = qA.pop_front();
            chk({tag, " A rsp_valid"}, 32'(busA.rsp_valid), 32'd1);
            chk({tag, " A rsp_err"},   32'(busA.rsp_err),   32'(e.err));
            chk({tag, " A rdata"},     busA.rdata,          e.rdata);
        end else begin
            chk({tag, " A idle rsp_valid"}, 32'(busA.rsp_valid), 32'd0);
            chk({tag, " A idle rdata"},     busA.rdata,          32'd0);
        end
        if (qB.size() > 0) begin
            e = qB.pop_front();
            chk({tag, " B rsp_valid"}, 32'(busB.rsp_valid), 32'd1);
            chk({tag, " B rsp_err"},   32'(busB.rsp_err),   32'(e.err));
            chk({tag, " B rdata"},     busB.rdata,          e.rdata);
        end else begin
            chk({tag, " B idle rsp_valid"}, 32'(busB.rsp_valid), 32'd0);
            chk({tag, " B idle rdata"},     busB.rdata,          32'd0);
        end
    endtask

    // One request on instance d (0=A, 1=B); its response is checked one edge later.
    task automatic access(input int d, input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic expErr, input logic [31:0] expData);
        exp_t e;
        e.err   = expErr;
        e.rdata = expData;
        if (d == 0) begin
            busA.req_valid = 1'b1; busA.req_write = wr; busA.req_size = sz;
            busA.req_unsigned = uns; busA.addr = a; busA.wdata = wd;
            qA.push_back(e);
        end else begin
            busB.req_valid = 1'b1; busB.req_write = wr; busB.req_size = sz;
            busB.req_unsigned = uns; busB.addr = a; busB.wdata = wd;
            qB.push_back(e);
        end
        @(posedge clk);
        #1;
        idleInputs();
        checkRsp(tag);
    endtask

    task automatic addVec(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic err,
                          input logic [31:0] exp);
        vec_t v;
        v.name = name; v.wr = wr; v.sz = sz; v.uns = uns;
        v.addr = a; v.wd = wd; v.err = err; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        //      name        wr  size     uns  addr          wdata          err  rdata
        addVec("sw 0x0",    1, SZ_WORD, 0, 32'h0000_0000, 32'h0000_0001, 0, 32'h0);
        addVec("sw 0x4",    1, SZ_WORD, 0, 32'h0000_0004, 32'h0000_0ABC, 0, 32'h0);
        addVec("sw 0x8",    1, SZ_WORD, 0, 32'h0000_0008, 32'h0000_0112, 0, 32'h0);
        addVec("lw 0x0",    0, SZ_WORD, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_0001);
        addVec("lw 0x4",    0, SZ_WORD, 0, 32'h0000_0004, 32'h0,         0, 32'h0000_0ABC);
        addVec("lw 0x8",    0, SZ_WORD, 1, 32'h0000_0008, 32'h0,         0, 32'h0000_0112);
        addVec("sw 0x10",   1, SZ_WORD, 0, 32'h0000_0010, 32'h1122_3344, 0, 32'h0);
        addVec("sb 0x11",   1, SZ_BYTE, 0, 32'h0000_0011, 32'hFFFF_FFAA, 0, 32'h0);
        addVec("lw 0x10",   0, SZ_WORD, 0, 32'h0000_0010, 32'h0,         0, 32'h1122_AA44);
        addVec("lbu 0x11",  0, SZ_BYTE, 1, 32'h0000_0011, 32'h0,         0, 32'h0000_00AA);
        addVec("lb 0x11",   0, SZ_BYTE, 0, 32'h0000_0011, 32'h0,         0, 32'hFFFF_FFAA);
        addVec("lb 0x10",   0, SZ_BYTE, 0, 32'h0000_0010, 32'h0,         0, 32'h0000_0044);
        addVec("lb 0x13",   0, SZ_BYTE, 0, 32'h0000_0013, 32'h0,         0, 32'h0000_0011);
        addVec("sh 0x12",   1, SZ_HALF, 0, 32'h0000_0012, 32'hFFFF_8001, 0, 32'h0);
        addVec("lh 0x12",   0, SZ_HALF, 0, 32'h0000_0012, 32'h0,         0, 32'hFFFF_8001);
        addVec("lhu 0x12",  0, SZ_HALF, 1, 32'h0000_0012, 32'h0,         0, 32'h0000_8001);
        addVec("lh 0x10",   0, SZ_HALF, 0, 32'h0000_0010, 32'h0,         0, 32'hFFFF_AA44);
        addVec("lw 0x10b",  0, SZ_WORD, 0, 32'h0000_0010, 32'h0,         0, 32'h8001_AA44);
        addVec("lw 0x2",    0, SZ_WORD, 0, 32'h0000_0002, 32'h0,         1, 32'h0);
        addVec("sh 0x13",   1, SZ_HALF, 0, 32'h0000_0013, 32'h0000_FFFF, 1, 32'h0);
        addVec("ill 0x0",   1, SZ_ILL,  0, 32'h0000_0000, 32'hDEAD_BEEF, 1, 32'h0);
        addVec("lw 0x0b",   0, SZ_WORD, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_0001);
        addVec("lw 0x10c",  0, SZ_WORD, 0, 32'h0000_0010, 32'h0,         0, 32'h8001_AA44);

        // Reset state
        rst_n = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset A rsp_valid", 32'(busA.rsp_valid), 32'd0);
        chk("reset A rsp_err",   32'(busA.rsp_err),   32'd0);
        chk("reset A rdata",     busA.rdata,          32'd0);
        chk("reset A err_count", 32'(busA.err_count), 32'd0);
        chk("reset B rsp_valid", 32'(busB.rsp_valid), 32'd0);
        chk("reset B err_count", 32'(busB.err_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkRsp("post reset");

        // Table-driven loads/stores on instance A
        for (int i = 0; i < vecs.size(); i++) begin
            access(0, vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].uns,
                   vecs[i].addr, vecs[i].wd, vecs[i].err, vecs[i].exp);
        end
        chk("A err_count after misaligned", 32'(busA.err_count), 32'd3);

        // Out-of-range on A; top in-range word and first out-of-range word
        access(0, "A sw 0xC008 oor", 1'b1, SZ_WORD, 1'b0, 32'h0000_C008, 32'h0000_0CBA, 1'b1, 32'h0);
        access(0, "A lw 0x8 kept",   1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0112);
        access(0, "A sw 0xFFC",      1'b1, SZ_WORD, 1'b0, 32'h0000_0FFC, 32'h0000_5A5A, 1'b0, 32'h0);
        access(0, "A lw 0xFFC",      1'b0, SZ_WORD, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0000_5A5A);
        access(0, "A lw 0x1000 oor", 1'b0, SZ_WORD, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0);
        chk("A err_count after oor", 32'(busA.err_count), 32'd5);

        // Wrap on B, then saturate its 2-bit error counter
        access(1, "B sw 0x8",         1'b1, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0000_0112, 1'b0, 32'h0);
        access(1, "B sw 0xC008 wrap", 1'b1, SZ_WORD, 1'b0, 32'h0000_C008, 32'h0000_0CBA, 1'b0, 32'h0);
        access(1, "B lw 0x8 wrapped", 1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0CBA);
        chk("B err_count no err", 32'(busB.err_count), 32'd0);
        access(1, "B err1", 1'b0, SZ_WORD, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 32'h0);
        access(1, "B err2", 1'b0, SZ_HALF, 1'b0, 32'h0000_0001, 32'h0, 1'b1, 32'h0);
        chk("B err_count 2", 32'(busB.err_count), 32'd2);
        for (int i = 0; i < 3; i++) begin
            access(1, "B errsat", 1'b0, SZ_ILL, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0);
        end
        chk("B err_count saturated", 32'(busB.err_count), 32'd3);

        // Back-to-back store then load of the same word
        access(0, "b2b sw 0x20", 1'b1, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0000_0055, 1'b0, 32'h0);
        access(0, "b2b lw 0x20", 1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0055);

        // Reset asserted while a request is pending: outputs clear at once
        busA.req_valid = 1'b1; busA.req_write = 1'b0; busA.req_size = SZ_WORD;
        busA.addr = 32'h0000_0020;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset A rsp_valid", 32'(busA.rsp_valid), 32'd0);
        chk("midreset A rdata",     busA.rdata,          32'd0);
        chk("midreset A err_count", 32'(busA.err_count), 32'd0);
        chk("midreset B err_count", 32'(busB.err_count), 32'd0);
        idleInputs();
        qA.delete();
        qB.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkRsp("after midreset");
        access(0, "lw 0x20 survives reset", 1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0055);
        access(0, "lhu 0x20",               1'b0, SZ_HALF, 1'b1, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
